// File: rtl/program_loader.sv
// Boot loader: parses a length header from the UART word stream, writes the
// payload into instruction memory, verifies a trailing checksum and acks the host.
module program_loader #(
  parameter int unsigned        ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [7:0]         ACK_OK    = 8'hAA,
  parameter logic [7:0]         ACK_NG    = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rword,
  input  logic              rword_ready,
  input  logic              ferr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              ack_valid,
  output logic [7:0]        ack_byte,
  input  logic              ack_ready,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {WAIT_LEN, LOAD, WAIT_SUM, ACK, DONE} state_t;

  localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       sum_q, sum_d;
  logic              ok_q, ok_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              ack_valid_q, ack_valid_d;
  logic [7:0]        ack_byte_q, ack_byte_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              take_err;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    ok_d        = ok_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_valid_d = ack_valid_q;
    ack_byte_d  = ack_byte_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    take_err    = 1'b0;

    unique case (state_q)
      WAIT_LEN: begin
        if (ferr) begin
          take_err = 1'b1;
        end else if (rword_ready) begin
          len_d      = rword[ADDR_W:0];
          sum_d      = '0;
          count_d    = '0;
          mem_addr_d = BASE_ADDR;
          load_err_d = 1'b0;
          ok_d       = 1'b0;
          if ({1'b0, rword} > MAX_LEN) take_err = 1'b1;
          else if (rword == '0)        state_d  = WAIT_SUM;
          else                         state_d  = LOAD;
        end
      end
      LOAD: begin
        if (ferr) begin
          take_err = 1'b1;
        end else if (rword_ready) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = rword;
          mem_addr_d  = BASE_ADDR + count_q[ADDR_W-1:0];
          sum_d       = sum_q + rword;
          count_d     = count_q + 1'b1;
          if (count_d == len_q) state_d = WAIT_SUM;
        end
      end
      WAIT_SUM: begin
        if (ferr) begin
          take_err = 1'b1;
        end else if (rword_ready) begin
          if (rword == sum_q) begin
            ack_byte_d  = ACK_OK;
            ack_valid_d = 1'b1;
            ok_d        = 1'b1;
            state_d     = ACK;
          end else begin
            take_err = 1'b1;
          end
        end
      end
      ACK: begin
        // After the handshake a failed load lingers here until ferr clears.
        if (ack_valid_q) begin
          if (ack_ready) begin
            ack_valid_d = 1'b0;
            if (ok_q) begin
              load_done_d = 1'b1;
              state_d     = DONE;
            end else if (!ferr) begin
              state_d = WAIT_LEN;
            end
          end
        end else if (!ok_q && !ferr) begin
          state_d = WAIT_LEN;
        end
      end
      DONE: ;
      default: state_d = WAIT_LEN;
    endcase

    if (take_err) begin
      load_err_d  = 1'b1;
      ack_byte_d  = ACK_NG;
      ack_valid_d = 1'b1;
      ok_d        = 1'b0;
      state_d     = ACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= WAIT_LEN;
      len_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      ok_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      ack_valid_q <= 1'b0;
      ack_byte_q  <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      ok_q        <= ok_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_valid_q <= ack_valid_d;
      ack_byte_q  <= ack_byte_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack_valid = ack_valid_q;
  assign ack_byte  = ack_byte_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
